// File: rtl/gen3_descrambler_if.sv
// Per-lane receive beat bus between block alignment and the Gen3 descrambler.
// The master modport drives received beats; the slave modport is the descrambler.
interface gen3_descrambler_if;
    logic        valid_i;
    logic        block_start_i;
    logic [1:0]  sync_hdr_i;
    logic [1:0]  data_len_i;
    logic [31:0] indata_i;
    logic        descramble_enable_i;
    logic        valid_o;
    logic [1:0]  data_len_o;
    logic [31:0] descrambled_data_o;
    logic        os_o;
    logic        lock_o;
    logic        blk_err_o;

    modport master (
        output valid_i, block_start_i, sync_hdr_i, data_len_i, indata_i, descramble_enable_i,
        input  valid_o, data_len_o, descrambled_data_o, os_o, lock_o, blk_err_o
    );

    modport slave (
        input  valid_i, block_start_i, sync_hdr_i, data_len_i, indata_i, descramble_enable_i,
        output valid_o, data_len_o, descrambled_data_o, os_o, lock_o, blk_err_o
    );
endinterface

// File: rtl/gen3_descrambler.sv
// 128b/130b receive descrambler for one lane: byte-serial Gen3 LFSR, block tracking and lock.
// Optional EIEOS pattern checking is enabled with the macro GEN3_DESCR_EIEOS_CHECK_EN.
module gen3_descrambler #(
    parameter int unsigned BLOCK_BYTES = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [2:0]   lane_number,
    gen3_descrambler_if.slave bus
);
    localparam int unsigned CntW = $clog2(BLOCK_BYTES);
    localparam logic [22:0] Taps = 23'h210125;

    typedef enum logic [1:0] {StUnlocked, StInBlock, StIdleBlk} state_e;
    typedef enum logic [1:0] {BlkData, BlkEieos, BlkSkp, BlkOs} blk_e;

    function automatic logic [22:0] seed_of(input logic [2:0] lane);
        logic [22:0] s;
        unique case (lane)
            3'd0: s = 23'h1DBFBC;
            3'd1: s = 23'h0607BB;
            3'd2: s = 23'h1EC760;
            3'd3: s = 23'h18C0DB;
            3'd4: s = 23'h010F12;
            3'd5: s = 23'h19CFC9;
            3'd6: s = 23'h0277CE;
            3'd7: s = 23'h1BB807;
        endcase
        return s;
    endfunction

    state_e          state_q, state_d;
    blk_e            blk_q, blk_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [22:0]     lfsr_q, lfsr_d;
    logic            lock_q, lock_d;
    logic            valid_q, os_q, err_q;
    logic [1:0]      len_q;
    logic [31:0]     data_q;
`ifdef GEN3_DESCR_EIEOS_CHECK_EN
    logic            eieos_bad_q, eieos_bad_d;
`endif

    logic            beat_ok, beat_err, reload_ok;
    logic [3:0]      byte_en;
    logic [CntW:0]   len_bytes, pos, sum;
    logic [CntW-1:0] base;
    logic [22:0]     lfsr_v, nxt;
    logic [7:0]      ks, in_byte;
    logic [31:0]     out_data;

    assign beat_ok = bus.valid_i && (bus.data_len_i != 2'b11);

    always_comb begin
        byte_en   = 4'b0000;
        len_bytes = '0;
        unique case (bus.data_len_i)
            2'b00:   begin byte_en = 4'b0001; len_bytes = (CntW+1)'(1); end
            2'b01:   begin byte_en = 4'b0011; len_bytes = (CntW+1)'(2); end
            2'b10:   begin byte_en = 4'b1111; len_bytes = (CntW+1)'(4); end
            default: begin byte_en = 4'b0000; len_bytes = '0; end
        endcase
    end

    always_comb begin
        state_d   = state_q;
        blk_d     = blk_q;
        cnt_d     = cnt_q;
        lfsr_d    = lfsr_q;
        lock_d    = lock_q;
        beat_err  = bus.valid_i && (bus.data_len_i == 2'b11);
        reload_ok = 1'b1;
        base      = cnt_q;
        pos       = '0;
        sum       = '0;
        lfsr_v    = lfsr_q;
        nxt       = lfsr_q;
        ks        = '0;
        in_byte   = '0;
        out_data  = '0;
`ifdef GEN3_DESCR_EIEOS_CHECK_EN
        eieos_bad_d = eieos_bad_q;
`endif
        if (beat_ok) begin
            if (bus.block_start_i) begin
                base     = '0;
                beat_err = (cnt_q != '0);
`ifdef GEN3_DESCR_EIEOS_CHECK_EN
                eieos_bad_d = 1'b0;
`endif
                unique case (bus.sync_hdr_i)
                    2'b10: blk_d = BlkData;
                    2'b01: blk_d = (bus.indata_i[7:0] == 8'h00) ? BlkEieos :
                                   (bus.indata_i[7:0] == 8'hAA) ? BlkSkp : BlkOs;
                    default: begin
                        blk_d    = BlkSkp;
                        beat_err = 1'b1;
                    end
                endcase
            end
            // Byte n sees the LFSR after bytes 0..n-1 of the same beat.
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    pos     = {1'b0, base} + (CntW+1)'(b);
                    in_byte = bus.indata_i[8*b +: 8];
                    nxt     = lfsr_v;
                    for (int k = 0; k < 8; k++) begin
                        ks[k] = nxt[22];
                        nxt   = {nxt[21:0], 1'b0} ^ (nxt[22] ? Taps : 23'h0);
                    end
                    out_data[8*b +: 8] = (blk_d == BlkData && bus.descramble_enable_i) ?
                                         (in_byte ^ ks) : in_byte;
                    if (blk_d != BlkSkp) lfsr_v = nxt;
`ifdef GEN3_DESCR_EIEOS_CHECK_EN
                    if (blk_d == BlkEieos && in_byte != (pos[0] ? 8'hFF : 8'h00)) begin
                        eieos_bad_d = 1'b1;
                        beat_err    = 1'b1;
                        lock_d      = 1'b0;
                    end
                    reload_ok = !eieos_bad_d;
`endif
                    if (blk_d == BlkEieos && pos == (CntW+1)'(BLOCK_BYTES - 1) && reload_ok) begin
                        lfsr_v = seed_of(lane_number);
                        lock_d = 1'b1;
                    end
                end
            end
            lfsr_d = lfsr_v;
            sum    = {1'b0, base} + len_bytes;
            if (sum > (CntW+1)'(BLOCK_BYTES)) begin
                beat_err = 1'b1;
                cnt_d    = '0;
            end else if (sum == (CntW+1)'(BLOCK_BYTES)) begin
                cnt_d = '0;
            end else begin
                cnt_d = sum[CntW-1:0];
            end
            if (bus.block_start_i || state_q == StInBlock) begin
                state_d = (cnt_d == '0) ? StIdleBlk : StInBlock;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StUnlocked;
            blk_q   <= BlkData;
            cnt_q   <= '0;
            lfsr_q  <= seed_of(lane_number);
            lock_q  <= 1'b0;
            valid_q <= 1'b0;
            os_q    <= 1'b0;
            err_q   <= 1'b0;
            len_q   <= 2'b00;
            data_q  <= '0;
`ifdef GEN3_DESCR_EIEOS_CHECK_EN
            eieos_bad_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            blk_q   <= blk_d;
            cnt_q   <= cnt_d;
            lfsr_q  <= lfsr_d;
            lock_q  <= lock_d;
            valid_q <= beat_ok;
            err_q   <= beat_err;
`ifdef GEN3_DESCR_EIEOS_CHECK_EN
            eieos_bad_q <= eieos_bad_d;
`endif
            if (beat_ok) begin
                data_q <= out_data;
                len_q  <= bus.data_len_i;
                os_q   <= (blk_d != BlkData);
            end
        end
    end

    assign bus.valid_o            = valid_q;
    assign bus.data_len_o         = len_q;
    assign bus.descrambled_data_o = data_q;
    assign bus.os_o               = os_q;
    assign bus.lock_o             = lock_q;
    assign bus.blk_err_o          = err_q;
endmodule

// File: tb/tb_gen3_descrambler.sv
// Self-checking bench for gen3_descrambler: a transmit-side scrambler model feeds beats and
// queues the plaintext each beat must descramble to; a negedge monitor pops and compares.
module tb_gen3_descrambler;
    localparam int T_DATA = 0, T_EIEOS = 1, T_SKP = 2, T_OS = 3;

    typedef struct packed {
        logic        valid;
        logic        err;
        logic        os;
        logic        lock;
        logic [1:0]  len;
        logic [31:0] data;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [2:0]  cur_lane = 3'd0;

    logic [22:0] seeds [8] = '{23'h1DBFBC, 23'h0607BB, 23'h1EC760, 23'h18C0DB,
                               23'h010F12, 23'h19CFC9, 23'h0277CE, 23'h1BB807};

    exp_t        exp_q [$];
    int          n_checks = 0;
    int          n_fail = 0;

    logic [22:0] tx_lfsr;
    int          m_pos, m_type;
    bit          m_lock, m_bad;

    gen3_descrambler_if bus ();

    gen3_descrambler dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .lane_number (cur_lane),
        .bus         (bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    // Transmit-side Galois LFSR, one byte of keystream, LSB first.
    task automatic tx_step(output logic [7:0] ks);
        logic       fb;
        logic [22:0] n;
        for (int k = 0; k < 8; k++) begin
            fb    = tx_lfsr[22];
            ks[k] = fb;
            n     = {tx_lfsr[21:0], 1'b0};
            n[0]  = fb;
            n[2]  = n[2] ^ fb;
            n[5]  = n[5] ^ fb;
            n[8]  = n[8] ^ fb;
            n[16] = n[16] ^ fb;
            n[21] = n[21] ^ fb;
            tx_lfsr = n;
        end
    endtask

    task automatic idle_inputs();
        bus.valid_i             = 1'b0;
        bus.block_start_i       = 1'b0;
        bus.sync_hdr_i          = 2'b00;
        bus.data_len_i          = 2'b00;
        bus.indata_i            = '0;
        bus.descramble_enable_i = 1'b1;
    endtask

    task automatic do_reset(input logic [2:0] lane);
        @(negedge clk_i);
        #1;
        idle_inputs();
        cur_lane = lane;
        rst_i    = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i   = 1'b0;
        tx_lfsr = seeds[lane];
        m_pos   = 0;
        m_type  = T_DATA;
        m_lock  = 1'b0;
        m_bad   = 1'b0;
    endtask

    // payload is the plaintext (data) or raw bytes (ordered sets); called just after a posedge.
    task automatic send(input bit start, input logic [1:0] sync, input logic [1:0] len,
                        input logic [31:0] payload, input bit exp_err);
        exp_t        e;
        logic [31:0] drv, mask;
        logic [7:0]  ks;
        int          nb;
        drv  = payload;
        mask = '0;
        nb   = (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : (len == 2'b10) ? 4 : 0;
        if (nb != 0) begin
            if (start) begin
                m_pos = 0;
                m_bad = 1'b0;
                if (sync == 2'b10)      m_type = T_DATA;
                else if (sync == 2'b01) m_type = (payload[7:0] == 8'h00) ? T_EIEOS :
                                                 (payload[7:0] == 8'hAA) ? T_SKP : T_OS;
                else                    m_type = T_SKP;
            end
            for (int b = 0; b < nb; b++) begin
                mask[8*b +: 8] = 8'hFF;
                if (m_type != T_SKP) begin
                    tx_step(ks);
                    if (m_type == T_DATA) drv[8*b +: 8] = payload[8*b +: 8] ^ ks;
                end
`ifdef GEN3_DESCR_EIEOS_CHECK_EN
                if (m_type == T_EIEOS && payload[8*b +: 8] != ((m_pos % 2 == 1) ? 8'hFF : 8'h00))
                begin
                    m_bad  = 1'b1;
                    m_lock = 1'b0;
                end
`endif
                if (m_type == T_EIEOS && m_pos == 15 && !m_bad) begin
                    tx_lfsr = seeds[cur_lane];
                    m_lock  = 1'b1;
                end
                m_pos++;
            end
            if (m_pos >= 16) m_pos = 0;
        end
        e.valid = (nb != 0);
        e.err   = exp_err;
        e.os    = (m_type != T_DATA);
        e.lock  = m_lock;
        e.len   = len;
        e.data  = payload & mask;
        bus.valid_i       = 1'b1;
        bus.block_start_i = start;
        bus.sync_hdr_i    = sync;
        bus.data_len_i    = len;
        bus.indata_i      = drv;
        @(posedge clk_i);
        exp_q.push_back(e);
        #1;
        bus.valid_i       = 1'b0;
        bus.block_start_i = 1'b0;
    endtask

    task automatic eieos_block();
        for (int i = 0; i < 4; i++) send(i == 0, 2'b01, 2'b10, 32'hFF00FF00, 1'b0);
    endtask

    always @(negedge clk_i) begin
        exp_t e;
        if (!rst_i) begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_eq("valid_o", 32'(bus.valid_o), 32'(e.valid));
                check_eq("blk_err_o", 32'(bus.blk_err_o), 32'(e.err));
                if (e.valid) begin
                    check_eq("data_o", bus.descrambled_data_o, e.data);
                    check_eq("data_len_o", 32'(bus.data_len_o), 32'(e.len));
                    check_eq("os_o", 32'(bus.os_o), 32'(e.os));
                    check_eq("lock_o", 32'(bus.lock_o), 32'(e.lock));
                end
            end else begin
                check_eq("idle_valid_o", 32'(bus.valid_o), 32'd0);
                check_eq("idle_blk_err_o", 32'(bus.blk_err_o), 32'd0);
            end
        end
    end

    initial begin
        idle_inputs();
        do_reset(3'd0);
        check_eq("rst_valid_o", 32'(bus.valid_o), 32'd0);
        check_eq("rst_lock_o", 32'(bus.lock_o), 32'd0);
        check_eq("rst_os_o", 32'(bus.os_o), 32'd0);
        check_eq("rst_blk_err_o", 32'(bus.blk_err_o), 32'd0);
        check_eq("rst_data_o", bus.descrambled_data_o, 32'd0);
        check_eq("rst_data_len_o", 32'(bus.data_len_o), 32'd0);
        check_eq("rst_lfsr", 32'(dut.lfsr_q), 32'h1DBFBC);

        // EIEOS on lane 0 reloads the seed and sets lock.
        eieos_block();
        check_eq("eieos_lfsr_reload", 32'(dut.lfsr_q), 32'h1DBFBC);
        // Mixed beat sizes: 4+4+2+2+1+1+2 = 16 bytes.
        send(1'b1, 2'b10, 2'b10, 32'hDEADBEEF, 1'b0);
        send(1'b0, 2'b10, 2'b10, 32'h01020304, 1'b0);
        send(1'b0, 2'b10, 2'b01, 32'h0000A5A5, 1'b0);
        send(1'b0, 2'b10, 2'b01, 32'h00003C3C, 1'b0);
        send(1'b0, 2'b10, 2'b00, 32'h00000081, 1'b0);
        send(1'b0, 2'b10, 2'b00, 32'h0000007E, 1'b0);
        send(1'b0, 2'b10, 2'b01, 32'h0000FFFF, 1'b0);

        // Reset mid-block discards the partial block.
        send(1'b1, 2'b10, 2'b10, 32'h11111111, 1'b0);
        send(1'b0, 2'b10, 2'b10, 32'h22222222, 1'b0);
        do_reset(3'd3);
        check_eq("midrst_lock_o", 32'(bus.lock_o), 32'd0);
        check_eq("midrst_lfsr", 32'(dut.lfsr_q), 32'h18C0DB);

        // Loopback on lane 3 while unlocked.
        send(1'b1, 2'b10, 2'b10, 32'h12345678, 1'b0);
        send(1'b0, 2'b10, 2'b10, 32'h9ABCDEF0, 1'b0);
        send(1'b0, 2'b10, 2'b10, 32'h00000000, 1'b0);
        send(1'b0, 2'b10, 2'b10, 32'hFFFFFFFF, 1'b0);

        eieos_block();
        // Data, SKP, data: SKP must not advance the LFSR.
        for (int i = 0; i < 4; i++) send(i == 0, 2'b10, 2'b10, 32'hC0DE0000 + 32'(i), 1'b0);
        for (int i = 0; i < 4; i++) send(i == 0, 2'b01, 2'b10, 32'h55AAAAAA ^ 32'(i << 8), 1'b0);
        for (int i = 0; i < 4; i++) send(i == 0, 2'b10, 2'b10, 32'hBEEF0000 + 32'(i), 1'b0);

        // TS1 ordered set passes raw but advances.
        for (int i = 0; i < 4; i++) send(i == 0, 2'b01, 2'b10, 32'h4A4A4A1E, 1'b0);

        // block_start_i at counter 8.
        send(1'b1, 2'b10, 2'b10, 32'hAAAA0001, 1'b0);
        send(1'b0, 2'b10, 2'b10, 32'hAAAA0002, 1'b0);
        send(1'b1, 2'b10, 2'b10, 32'hBBBB0001, 1'b1);
        for (int i = 2; i <= 4; i++) send(1'b0, 2'b10, 2'b10, 32'hBBBB0000 + 32'(i), 1'b0);

        // Illegal length mid-block is dropped.
        send(1'b1, 2'b10, 2'b10, 32'hCCCC0001, 1'b0);
        send(1'b0, 2'b10, 2'b10, 32'hCCCC0002, 1'b0);
        send(1'b0, 2'b10, 2'b11, 32'hCCCC0BAD, 1'b1);
        send(1'b0, 2'b10, 2'b10, 32'hCCCC0003, 1'b0);
        send(1'b0, 2'b10, 2'b10, 32'hCCCC0004, 1'b0);

        // Bad sync header: error, treated as SKP.
        send(1'b1, 2'b11, 2'b10, 32'h13572468, 1'b1);
        for (int i = 0; i < 3; i++) send(1'b0, 2'b11, 2'b10, 32'h0F0F0F0F, 1'b0);

        // Beat crossing the block boundary without block_start_i.
        send(1'b1, 2'b10, 2'b10, 32'hDDDD0001, 1'b0);
        send(1'b0, 2'b10, 2'b10, 32'hDDDD0002, 1'b0);
        send(1'b0, 2'b10, 2'b10, 32'hDDDD0003, 1'b0);
        send(1'b0, 2'b10, 2'b01, 32'h0000D004, 1'b0);
        send(1'b0, 2'b10, 2'b10, 32'hDDDD0005, 1'b1);
        for (int i = 0; i < 4; i++) send(i == 0, 2'b10, 2'b10, 32'hEEEE0000 + 32'(i), 1'b0);

`ifdef GEN3_DESCR_EIEOS_CHECK_EN
        // Corrupted EIEOS byte 5: error, lock clears, no reload.
        send(1'b1, 2'b01, 2'b10, 32'hFF00FF00, 1'b0);
        send(1'b0, 2'b01, 2'b10, 32'hFF000000, 1'b1);
        send(1'b0, 2'b01, 2'b10, 32'hFF00FF00, 1'b0);
        send(1'b0, 2'b01, 2'b10, 32'hFF00FF00, 1'b0);
        for (int i = 0; i < 4; i++) send(i == 0, 2'b10, 2'b10, 32'h77770000 + 32'(i), 1'b0);
`endif

        repeat (3) @(posedge clk_i);
        check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
